// File: rtl/regfile_scoreboard_pkg.sv
// Shared sizing parameters and helpers for the register file with write-pending scoreboard.
package regfile_scoreboard_pkg;

    localparam int W_RD_DEF  = 5;
    localparam int W_OPR_DEF = 32;
    localparam int W_CNT_DEF = 2;
    localparam int N_REG_DEF = 1 << W_RD_DEF;

    function automatic int cnt_max(input int w_cnt);
        return (1 << w_cnt) - 1;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-write counters, effective-count stall decode and sticky protocol error.
module reg_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int W_RD  = W_RD_DEF,
    parameter int N_REG = N_REG_DEF,
    parameter int W_CNT = W_CNT_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [W_RD-1:0] r0_i,
    input  logic [W_RD-1:0] r1_i,
    input  logic            w_reserve_i,
    input  logic            wb_v_i,
    input  logic [W_RD-1:0] wb_r_i,
    output logic            reserved_o,
    output logic            err_o
);

    localparam logic [W_CNT-1:0] CNT_MAX = W_CNT'(cnt_max(W_CNT));
    localparam logic [W_CNT-1:0] CNT_ONE = W_CNT'(1);

    logic [W_CNT-1:0] cnt [N_REG];
    logic [W_CNT-1:0] cnt_r0, cnt_r1, cnt_wb;
    logic [W_CNT-1:0] eff_r0, eff_r1;
    logic             full_r0;
    logic             res_en, wb_en, same_reg;
    logic             inc, dec, res_err, wb_err;

    always_comb begin
        cnt_r0  = cnt[r0_i];
        cnt_r1  = cnt[r1_i];
        cnt_wb  = cnt[wb_r_i];
        full_r0 = (cnt_r0 == CNT_MAX);
        // A writeback landing this cycle retires one pending write, so the reader need not wait for it.
        eff_r0 = (wb_v_i && wb_r_i == r0_i && cnt_r0 != '0) ? cnt_r0 - CNT_ONE : cnt_r0;
        eff_r1 = (wb_v_i && wb_r_i == r1_i && cnt_r1 != '0) ? cnt_r1 - CNT_ONE : cnt_r1;
        reserved_o = ((r0_i != '0) && ((eff_r0 != '0) || (w_reserve_i && full_r0)))
                  || ((r1_i != '0) && (eff_r1 != '0));

        res_en   = w_reserve_i && (r0_i != '0);
        wb_en    = wb_v_i && (wb_r_i != '0);
        // Reserve and writeback on the same register cancel out in the counter.
        same_reg = res_en && wb_en && (r0_i == wb_r_i);
        inc      = res_en && !same_reg && !full_r0;
        dec      = wb_en && !same_reg && (cnt_wb != '0);
        res_err  = res_en && !same_reg && full_r0;
        wb_err   = wb_en && !same_reg && (cnt_wb == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < N_REG; k++) begin
                cnt[k] <= '0;
            end
            err_o <= 1'b0;
        end else begin
            if (inc) begin
                cnt[r0_i] <= cnt_r0 + CNT_ONE;
            end
            if (dec) begin
                cnt[wb_r_i] <= cnt_wb - CNT_ONE;
            end
            if (res_err || wb_err) begin
                err_o <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with combinational reads, writeback bypass and a write-pending scoreboard for decode stalls.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int W_RD  = W_RD_DEF,
    parameter int W_OPR = W_OPR_DEF,
    parameter int N_REG = 2 ** W_RD,
    parameter int W_CNT = W_CNT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [W_RD-1:0]  r0_i,
    input  logic [W_RD-1:0]  r1_i,
    input  logic             w_reserve_i,
    output logic [W_OPR-1:0] r_opr0_o,
    output logic [W_OPR-1:0] r_opr1_o,
    output logic             reserved_o,
    input  logic             wb_v_i,
    input  logic [W_RD-1:0]  wb_r_i,
    input  logic [W_OPR-1:0] wb_data_i,
    output logic             err_o
);

    logic [W_OPR-1:0] regs [N_REG];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < N_REG; k++) begin
                regs[k] <= '0;
            end
        end else if (wb_v_i && wb_r_i != '0) begin
            regs[wb_r_i] <= wb_data_i;
        end
    end

    always_comb begin
        r_opr0_o = regs[r0_i];
        r_opr1_o = regs[r1_i];
        if (r0_i == '0) begin
            r_opr0_o = '0;
        end else if (wb_v_i && wb_r_i == r0_i) begin
            r_opr0_o = wb_data_i;
        end
        if (r1_i == '0) begin
            r_opr1_o = '0;
        end else if (wb_v_i && wb_r_i == r1_i) begin
            r_opr1_o = wb_data_i;
        end
    end

    reg_scoreboard #(
        .W_RD  (W_RD),
        .N_REG (N_REG),
        .W_CNT (W_CNT)
    ) u_reg_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .r0_i        (r0_i),
        .r1_i        (r1_i),
        .w_reserve_i (w_reserve_i),
        .wb_v_i      (wb_v_i),
        .wb_r_i      (wb_r_i),
        .reserved_o  (reserved_o),
        .err_o       (err_o)
    );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: stimulus queues expected outputs, a negedge monitor compares.
module tb_regfile_scoreboard;

    localparam int W_RD  = 5;
    localparam int W_OPR = 32;
    localparam int N_REG = 32;
    localparam int W_CNT = 2;

    typedef struct {
        string            name;
        logic [W_OPR-1:0] opr0;
        logic [W_OPR-1:0] opr1;
        logic             rsv;
        logic             err;
    } exp_t;

    logic             clk;
    logic             reset;
    logic [W_RD-1:0]  r0;
    logic [W_RD-1:0]  r1;
    logic             w_reserve;
    logic [W_OPR-1:0] r_opr0;
    logic [W_OPR-1:0] r_opr1;
    logic             reserved;
    logic             wb_v;
    logic [W_RD-1:0]  wb_r;
    logic [W_OPR-1:0] wb_data;
    logic             err;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    regfile_scoreboard #(
        .W_RD  (W_RD),
        .W_OPR (W_OPR),
        .N_REG (N_REG),
        .W_CNT (W_CNT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .r0_i        (r0),
        .r1_i        (r1),
        .w_reserve_i (w_reserve),
        .r_opr0_o    (r_opr0),
        .r_opr1_o    (r_opr1),
        .reserved_o  (reserved),
        .wb_v_i      (wb_v),
        .wb_r_i      (wb_r),
        .wb_data_i   (wb_data),
        .err_o       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (r_opr0 !== e.opr0) begin
                errors++;
                $display("FAIL %s r_opr0 got %h want %h", e.name, r_opr0, e.opr0);
            end
            checks++;
            if (r_opr1 !== e.opr1) begin
                errors++;
                $display("FAIL %s r_opr1 got %h want %h", e.name, r_opr1, e.opr1);
            end
            checks++;
            if (reserved !== e.rsv) begin
                errors++;
                $display("FAIL %s reserved got %b want %b", e.name, reserved, e.rsv);
            end
            checks++;
            if (err !== e.err) begin
                errors++;
                $display("FAIL %s err got %b want %b", e.name, err, e.err);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [W_RD-1:0] a0, input logic [W_RD-1:0] a1, input logic res,
                         input logic v, input logic [W_RD-1:0] wr, input logic [W_OPR-1:0] wd);
        r0        = a0;
        r1        = a1;
        w_reserve = res;
        wb_v      = v;
        wb_r      = wr;
        wb_data   = wd;
    endtask

    task automatic expect_out(input string name, input logic [W_OPR-1:0] o0, input logic [W_OPR-1:0] o1,
                              input logic rsv, input logic e);
        exp_t x;
        x.name = name;
        x.opr0 = o0;
        x.opr1 = o1;
        x.rsv  = rsv;
        x.err  = e;
        exp_q.push_back(x);
    endtask

    // Reset asserted between edges so the monitor sees the asynchronous clear.
    task automatic pulse_reset(input string name);
        drive(5'd5, 5'd3, 1'b0, 1'b0, 5'd0, '0);
        reset = 1'b1;
        expect_out(name, 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, '0);
        step();
        step();
        reset = 1'b0;

        drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, '0);
        expect_out("reset_read", 32'h0, 32'h0, 1'b0, 1'b0);
        step();

        drive(5'd3, 5'd0, 1'b1, 1'b0, 5'd0, '0);
        expect_out("rsv3_issue", 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        drive(5'd0, 5'd3, 1'b0, 1'b0, 5'd0, '0);
        expect_out("rsv3_stall", 32'h0, 32'h0, 1'b1, 1'b0);
        step();
        drive(5'd0, 5'd3, 1'b0, 1'b1, 5'd3, 32'h1234);
        expect_out("wb3_bypass", 32'h0, 32'h1234, 1'b0, 1'b0);
        step();
        drive(5'd0, 5'd3, 1'b0, 1'b0, 5'd0, '0);
        expect_out("wb3_stored", 32'h0, 32'h1234, 1'b0, 1'b0);
        step();

        drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd0, '0);
        expect_out("rsv5_a", 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        expect_out("rsv5_b", 32'h0, 32'h0, 1'b1, 1'b0);
        step();
        expect_out("rsv5_c", 32'h0, 32'h0, 1'b1, 1'b0);
        step();
        expect_out("rsv5_full", 32'h0, 32'h0, 1'b1, 1'b0);
        step();
        drive(5'd5, 5'd0, 1'b0, 1'b0, 5'd0, '0);
        expect_out("rsv5_overflow_err", 32'h0, 32'h0, 1'b1, 1'b1);
        step();
        drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 32'h51);
        expect_out("wb5_first", 32'h51, 32'h0, 1'b1, 1'b1);
        step();
        drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 32'h52);
        expect_out("wb5_second", 32'h52, 32'h0, 1'b1, 1'b1);
        step();
        drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 32'h53);
        expect_out("wb5_third", 32'h53, 32'h0, 1'b0, 1'b1);
        step();
        drive(5'd5, 5'd0, 1'b0, 1'b0, 5'd0, '0);
        expect_out("cnt5_drained", 32'h53, 32'h0, 1'b0, 1'b1);
        step();
        pulse_reset("reset_clears_err");

        drive(5'd7, 5'd0, 1'b1, 1'b0, 5'd0, '0);
        expect_out("rsv7", 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        drive(5'd7, 5'd0, 1'b1, 1'b1, 5'd7, 32'hAA);
        expect_out("rsv7_wb7_same", 32'hAA, 32'h0, 1'b0, 1'b0);
        step();
        drive(5'd7, 5'd0, 1'b0, 1'b0, 5'd0, '0);
        expect_out("cnt7_still_one", 32'hAA, 32'h0, 1'b1, 1'b0);
        step();
        drive(5'd7, 5'd0, 1'b0, 1'b1, 5'd7, 32'hBB);
        expect_out("wb7_retire", 32'hBB, 32'h0, 1'b0, 1'b0);
        step();
        drive(5'd7, 5'd0, 1'b0, 1'b0, 5'd0, '0);
        expect_out("cnt7_zero", 32'hBB, 32'h0, 1'b0, 1'b0);
        step();

        drive(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, '0);
        expect_out("rsv0_ignored", 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        drive(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 32'hFF);
        expect_out("wb0_no_bypass", 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, '0);
        expect_out("r0_reads_zero", 32'h0, 32'h0, 1'b0, 1'b0);
        step();

        drive(5'd4, 5'd0, 1'b1, 1'b0, 5'd0, '0);
        expect_out("rsv4", 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        drive(5'd10, 5'd4, 1'b1, 1'b1, 5'd4, 32'h44);
        expect_out("rsv10_wb4", 32'h0, 32'h44, 1'b0, 1'b0);
        step();
        drive(5'd10, 5'd4, 1'b0, 1'b0, 5'd0, '0);
        expect_out("both_effects", 32'h0, 32'h44, 1'b1, 1'b0);
        step();
        drive(5'd10, 5'd0, 1'b0, 1'b1, 5'd10, 32'h10);
        expect_out("wb10", 32'h10, 32'h0, 1'b0, 1'b0);
        step();

        drive(5'd9, 5'd0, 1'b1, 1'b0, 5'd0, '0);
        expect_out("rsv9", 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        drive(5'd9, 5'd0, 1'b0, 1'b0, 5'd0, '0);
        expect_out("rsv9_pending", 32'h0, 32'h0, 1'b1, 1'b0);
        step();
        pulse_reset("reset_midop");
        drive(5'd9, 5'd0, 1'b0, 1'b1, 5'd9, 32'h55);
        expect_out("wb9_after_reset", 32'h55, 32'h0, 1'b0, 1'b0);
        step();
        drive(5'd9, 5'd0, 1'b0, 1'b0, 5'd0, '0);
        expect_out("wb9_err", 32'h55, 32'h0, 1'b0, 1'b1);
        step();
        step();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending got %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
